// File: rtl/v850_pkg.sv
// v850_pkg: V850 instruction-length types, opcode constants and the length
// decode shared by the prefetch queue and the decoder.
package v850_pkg;
  typedef logic [1:0] inst_len_t;
  localparam logic [5:0] OP_JR32  = 6'b010111;
  localparam logic [5:0] OP_MOV32 = 6'b110001;
  localparam logic [5:0] OP_JMP32 = 6'b110111;
  localparam logic [5:0] OP_LDST0 = 6'b111100;
  localparam logic [5:0] OP_LDST1 = 6'b111101;
  function automatic inst_len_t v850_inst_len(input logic [15:0] h);
    logic [5:0] op;
    op = h[10:5];
    if (h[15:11] == 5'd0 && (op == OP_JR32 || op == OP_MOV32 || op == OP_JMP32 ||
                             op == OP_LDST0 || op == OP_LDST1))
      return 2'd3;
    return (h[10:9] == 2'b11) ? 2'd2 : 2'd1;
  endfunction
endpackage

// File: rtl/v850_fetch_queue.sv
// v850_fetch_queue: prefetch queue that fetches FETCH_W-bit blocks, buffers
// halfwords and hands out one complete 16/32/48-bit instruction per handshake.
module v850_fetch_queue
  import v850_pkg::*;
#(
  parameter int          FETCH_W  = 32,
  parameter int          DEPTH_HW = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [31:0]        flush_pc,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [31:0]        mem_req_addr,
  input  logic               mem_rsp_valid,
  input  logic [FETCH_W-1:0] mem_rsp_data,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [47:0]        inst_data,
  output inst_len_t          inst_len,
  output logic [31:0]        inst_pc
);
  localparam int HW = FETCH_W / 16;
  localparam int OB = $clog2(FETCH_W / 8);
  localparam int SW = OB - 1;
  localparam int PW = $clog2(DEPTH_HW);
  localparam int CW = $clog2(DEPTH_HW + 1);
  localparam logic [31:0] ALIGN_MASK = ~32'(FETCH_W / 8 - 1);

  function automatic logic [PW-1:0] wrap(input int p);
    return PW'((p >= DEPTH_HW) ? p - DEPTH_HW : p);
  endfunction

  logic [15:0]   q_q [DEPTH_HW];
  logic [15:0]   q_d [DEPTH_HW];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   head_pc_q, head_pc_d, fetch_addr_q, fetch_addr_d;
  logic          outstanding_q, outstanding_d, drop_q, drop_d, started_q, started_d;
  logic [SW-1:0] skip_hw_q, skip_hw_d;
  logic [15:0]   h0, h1, h2;
  inst_len_t     head_len;
  logic          rsp_fire, enq, pop;
  int            n_enq, n_pop;

  assign h0            = q_q[rd_ptr_q];
  assign h1            = q_q[wrap(int'(rd_ptr_q) + 1)];
  assign h2            = q_q[wrap(int'(rd_ptr_q) + 2)];
  assign head_len      = v850_inst_len(h0);
  assign inst_len      = head_len;
  assign inst_valid    = count_q >= CW'(head_len);
  assign inst_data     = {head_len == 2'd3 ? h2 : 16'h0, head_len != 2'd1 ? h1 : 16'h0, h0};
  assign inst_pc       = head_pc_q;
  // started_q keeps the request low for the first cycle out of reset
  assign mem_req_valid = started_q && !outstanding_q && !flush && (DEPTH_HW - int'(count_q) >= HW);
  assign mem_req_addr  = fetch_addr_q;
  assign rsp_fire      = outstanding_q && mem_rsp_valid;
  assign enq           = rsp_fire && !drop_q;
  assign pop           = inst_valid && inst_ready;

  always_comb begin
    q_d           = q_q;
    started_d     = 1'b1;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    skip_hw_d     = skip_hw_q;
    fetch_addr_d  = fetch_addr_q;
    n_enq         = enq ? HW - int'(skip_hw_q) : 0;
    n_pop         = pop ? int'(head_len) : 0;
    if (mem_req_valid && mem_req_ready) begin
      outstanding_d = 1'b1;
      fetch_addr_d  = fetch_addr_q + 32'(FETCH_W / 8);
    end
    if (rsp_fire) begin
      outstanding_d = 1'b0;
      drop_d        = 1'b0;
    end
    if (enq) begin
      for (int i = 0; i < HW; i++)
        if (i >= int'(skip_hw_q)) q_d[wrap(int'(wr_ptr_q) + i - int'(skip_hw_q))] = mem_rsp_data[16*i +: 16];
      skip_hw_d = '0;
    end
    wr_ptr_d  = wrap(int'(wr_ptr_q) + n_enq);
    rd_ptr_d  = wrap(int'(rd_ptr_q) + n_pop);
    count_d   = CW'(int'(count_q) + n_enq - n_pop);
    head_pc_d = head_pc_q + 32'(2 * n_pop);
    // a response landing in the flush cycle is already consumed, so only a
    // request still in flight afterwards needs its data dropped
    if (flush) begin
      count_d      = '0;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      head_pc_d    = flush_pc & ~32'd1;
      fetch_addr_d = flush_pc & ALIGN_MASK;
      skip_hw_d    = flush_pc[OB-1:1];
      drop_d       = outstanding_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_HW; i++) q_q[i] <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      head_pc_q     <= RESET_PC & ~32'd1;
      fetch_addr_q  <= RESET_PC & ALIGN_MASK;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      started_q     <= 1'b0;
      skip_hw_q     <= RESET_PC[OB-1:1];
    end else begin
      q_q           <= q_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      head_pc_q     <= head_pc_d;
      fetch_addr_q  <= fetch_addr_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      started_q     <= started_d;
      skip_hw_q     <= skip_hw_d;
    end
  end
endmodule
